// File: rtl/ethernet_tx_framer.sv
// Transmit-side Ethernet framer: preamble, SFD, payload, zero pad, CRC-32 FCS and
// interframe gap on a GMII-style byte stream in the 125 MHz ethernet clock domain.
module ethernet_tx_framer #(
  parameter int unsigned MIN_PAYLOAD = 60,
  parameter int unsigned IFG_BYTES   = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] io_in_data,
  input  logic       io_in_valid,
  input  logic       io_in_last,
  output logic       io_in_ready,
  output logic [7:0] io_tx_data,
  output logic       io_tx_en,
  output logic       io_tx_er,
  output logic       io_busy
);

  localparam int unsigned COUNT_W      = 11;
  localparam int unsigned STEP_W       = 16;
  localparam int unsigned PREAMBLE_LEN = 7;
  localparam int unsigned FCS_LEN      = 4;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PREAMBLE = 3'd1;
  localparam logic [2:0] SFD      = 3'd2;
  localparam logic [2:0] PAYLOAD  = 3'd3;
  localparam logic [2:0] PAD      = 3'd4;
  localparam logic [2:0] FCS      = 3'd5;
  localparam logic [2:0] DROP     = 3'd6;
  localparam logic [2:0] IFG      = 3'd7;

  logic [2:0]         state, state_d;
  logic [COUNT_W-1:0] count, count_d, count_inc;
  logic [STEP_W-1:0]  step, step_d, step_inc;
  logic [31:0]        crc, crc_d, crc_folded, crc_out;
  logic [7:0]         crc_byte_in;
  logic [7:0]         tx_data_d;
  logic               tx_en_d, tx_er_d;

  // Reflected CRC-32 update by one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h00_0000, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Pad bytes fold zeros; only payload bytes come from the input.
  assign crc_byte_in = (state == PAYLOAD) ? io_in_data : 8'h00;
  assign crc_folded  = crc_byte(crc, crc_byte_in);
  assign crc_out     = ~crc;
  assign count_inc   = (count == COUNT_MAX) ? count : count + COUNT_W'(1);
  assign step_inc    = step + STEP_W'(1);

  assign io_in_ready = (state == PAYLOAD) || (state == DROP);
  assign io_busy     = (state != IDLE);

  always_comb begin
    state_d   = state;
    count_d   = count;
    step_d    = step;
    crc_d     = crc;
    tx_data_d = 8'h00;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    case (state)
      IDLE: begin
        if (io_in_valid) begin
          state_d = PREAMBLE;
          count_d = '0;
          step_d  = '0;
          crc_d   = CRC_INIT;
        end
      end
      PREAMBLE: begin
        tx_data_d = 8'h55;
        tx_en_d   = 1'b1;
        step_d    = step_inc;
        if (step == STEP_W'(PREAMBLE_LEN - 1)) begin
          state_d = SFD;
          step_d  = '0;
        end
      end
      SFD: begin
        tx_data_d = 8'hD5;
        tx_en_d   = 1'b1;
        state_d   = PAYLOAD;
      end
      PAYLOAD: begin
        tx_en_d = 1'b1;
        if (io_in_valid) begin
          tx_data_d = io_in_data;
          crc_d     = crc_folded;
          count_d   = count_inc;
          if (io_in_last) begin
            state_d = (count_inc < COUNT_W'(MIN_PAYLOAD)) ? PAD : FCS;
          end
        end else begin
          // Underrun: mark the slot as errored and abandon the frame.
          tx_er_d = 1'b1;
          state_d = DROP;
        end
      end
      PAD: begin
        tx_en_d = 1'b1;
        crc_d   = crc_folded;
        count_d = count_inc;
        if (count_inc >= COUNT_W'(MIN_PAYLOAD)) begin
          state_d = FCS;
        end
      end
      FCS: begin
        tx_data_d = crc_out[{step[1:0], 3'b000} +: 8];
        tx_en_d   = 1'b1;
        step_d    = step_inc;
        if (step == STEP_W'(FCS_LEN - 1)) begin
          state_d = IFG;
          step_d  = '0;
        end
      end
      DROP: begin
        if (io_in_valid && io_in_last) begin
          state_d = IFG;
          step_d  = '0;
        end
      end
      IFG: begin
        step_d = step_inc;
        if (step == STEP_W'(IFG_BYTES - 1)) begin
          state_d = IDLE;
          step_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      step       <= '0;
      crc        <= CRC_INIT;
      io_tx_data <= 8'h00;
      io_tx_en   <= 1'b0;
      io_tx_er   <= 1'b0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      step       <= step_d;
      crc        <= crc_d;
      io_tx_data <= tx_data_d;
      io_tx_en   <= tx_en_d;
      io_tx_er   <= tx_er_d;
    end
  end

endmodule

// File: tb/tb_ethernet_tx_framer.sv
// Scoreboard bench for ethernet_tx_framer: a frame-level reference model pushes the
// expected wire bytes, a monitor pops and compares every transmitted byte.
module tb_ethernet_tx_framer;

  localparam int unsigned MIN_PAYLOAD = 60;
  localparam int unsigned IFG_BYTES   = 12;

  typedef logic [7:0] byte_q_t[$];

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] io_in_data;
  logic       io_in_valid;
  logic       io_in_last;
  logic       io_in_ready;
  logic [7:0] io_tx_data;
  logic       io_tx_en;
  logic       io_tx_er;
  logic       io_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]  sb_q[$];
  int          run_len[$];
  int          gap_len[$];
  logic [31:0] crc_tbl[256];

  ethernet_tx_framer #(.MIN_PAYLOAD(MIN_PAYLOAD), .IFG_BYTES(IFG_BYTES)) dut (
    .clock(clock), .reset(reset),
    .io_in_data(io_in_data), .io_in_valid(io_in_valid), .io_in_last(io_in_last),
    .io_in_ready(io_in_ready),
    .io_tx_data(io_tx_data), .io_tx_en(io_tx_en), .io_tx_er(io_tx_er), .io_busy(io_busy)
  );

  always #4 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Frame check sequence of a padded body, table-driven.
  function automatic logic [31:0] model_fcs(input byte_q_t body);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (body[i]) c = crc_tbl[c[7:0] ^ body[i]] ^ (c >> 8);
    return ~c;
  endfunction

  function automatic int expected_run(input int n, input int underrun_at);
    if (underrun_at >= 0) return 8 + underrun_at + 1;
    return 8 + ((n > int'(MIN_PAYLOAD)) ? n : int'(MIN_PAYLOAD)) + 4;
  endfunction

  // Expected wire image of one frame as {tx_er, tx_data}.
  task automatic push_expected(input byte_q_t p, input int underrun_at, input int cut_at);
    byte_q_t     body;
    logic [31:0] fcs;
    for (int i = 0; i < 7; i++) sb_q.push_back({1'b0, 8'h55});
    sb_q.push_back({1'b0, 8'hD5});
    if (cut_at >= 0) begin
      for (int i = 0; i < cut_at; i++) sb_q.push_back({1'b0, p[i]});
      return;
    end
    if (underrun_at >= 0) begin
      for (int i = 0; i < underrun_at; i++) sb_q.push_back({1'b0, p[i]});
      sb_q.push_back({1'b1, 8'h00});
      return;
    end
    body = p;
    while (body.size() < int'(MIN_PAYLOAD)) body.push_back(8'h00);
    foreach (body[i]) sb_q.push_back({1'b0, body[i]});
    fcs = model_fcs(body);
    for (int k = 0; k < 4; k++) sb_q.push_back({1'b0, fcs[8*k +: 8]});
  endtask

  // Drives one frame; optionally drops valid once (underrun) or asserts reset mid-frame.
  task automatic send(input byte_q_t p, input int underrun_at, input int reset_at,
                      output int stalls);
    int i = 0;
    int guard = 0;
    bit dropped = 1'b0;
    stalls = 0;
    while (i < p.size()) begin
      @(negedge clock);
      guard++;
      if (guard > 4000) begin
        timeout_fail("send_handshake");
        return;
      end
      if (i == reset_at) begin
        reset = 1'b1;
        io_in_valid = 1'b0;
        io_in_last = 1'b0;
        return;
      end
      if (!dropped && i == underrun_at && io_in_ready) begin
        io_in_valid = 1'b0;
        io_in_last = 1'b0;
        dropped = 1'b1;
      end else begin
        io_in_valid = 1'b1;
        io_in_data = p[i];
        io_in_last = (i == p.size() - 1);
        if (io_in_ready) i++;
        else if (dropped) stalls++;
      end
    end
  endtask

  task automatic release_inputs();
    @(negedge clock);
    io_in_valid = 1'b0;
    io_in_last = 1'b0;
    io_in_data = 8'h00;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (io_busy !== 1'b0) begin
      @(negedge clock);
      guard++;
      if (guard > 3000) begin
        timeout_fail("wait_idle");
        return;
      end
    end
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  // Monitor: compares every enabled byte with the scoreboard; tracks run and gap lengths.
  initial begin : monitor
    bit         in_run = 1'b0;
    bit         seen_run = 1'b0;
    int         cur = 0;
    int         gap = 0;
    logic [8:0] exp;
    forever begin
      @(posedge clock);
      #1;
      if (io_tx_en === 1'b1) begin
        if (!in_run) begin
          if (seen_run) gap_len.push_back(gap);
          in_run = 1'b1;
          cur = 0;
        end
        cur++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got data 0x%0h er %0b, expected no transmission at %0t",
                   io_tx_data, io_tx_er, $time);
        end else begin
          exp = sb_q.pop_front();
          check("tx_byte", 32'({io_tx_er, io_tx_data}), 32'(exp));
        end
      end else begin
        if (in_run) begin
          run_len.push_back(cur);
          in_run = 1'b0;
          seen_run = 1'b1;
          gap = 0;
        end
        gap++;
        check("idle_out", 32'({io_tx_er, io_tx_data}), 32'h0);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stimulus
    byte_q_t p, p2;
    int stalls, cnt, n, ur;

    for (int k = 0; k < 256; k++) begin
      logic [31:0] c;
      c = 32'(k);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tbl[k] = c;
    end

    // Reset held with valid high: nothing may start.
    reset = 1'b1;
    io_in_valid = 1'b1;
    io_in_last = 1'b0;
    io_in_data = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("rst_tx_en", 32'(io_tx_en), 32'h0);
      check("rst_tx_data", 32'(io_tx_data), 32'h0);
      check("rst_tx_er", 32'(io_tx_er), 32'h0);
      check("rst_ready", 32'(io_in_ready), 32'h0);
      check("rst_busy", 32'(io_busy), 32'h0);
    end
    reset = 1'b0;
    io_in_valid = 1'b0;
    @(negedge clock);
    check("post_rst_busy", 32'(io_busy), 32'h0);

    // Minimum-length frame 0x00..0x3B.
    p = {};
    for (int i = 0; i < 60; i++) p.push_back(8'(i));
    push_expected(p, -1, -1);
    send(p, -1, -1, stalls);
    release_inputs();
    wait_idle();
    check("min_frame_len", 32'(run_len[$]), 32'd72);

    // Single-byte frame padded to minimum length; ready must stay low while padding.
    p = {8'hAB};
    push_expected(p, -1, -1);
    send(p, -1, -1, stalls);
    cnt = 0;
    for (int c = 0; c < 59; c++) begin
      @(negedge clock);
      if (c == 0) begin
        io_in_valid = 1'b0;
        io_in_last = 1'b0;
      end
      if (io_in_ready) cnt++;
    end
    check("pad_ready_low", 32'(cnt), 32'h0);
    wait_idle();
    check("short_frame_len", 32'(run_len[$]), 32'd72);

    // Underrun after 10 of 100 bytes.
    p = rand_bytes(100);
    push_expected(p, 10, -1);
    send(p, 10, -1, stalls);
    check("drop_stalls", 32'(stalls), 32'h0);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (c == 0) begin
        io_in_valid = 1'b0;
        io_in_last = 1'b0;
      end
      if (!io_busy) break;
      cnt++;
    end
    check("drop_ifg_len", 32'(cnt), 32'(IFG_BYTES));
    check("underrun_run_len", 32'(run_len[$]), 32'(expected_run(100, 10)));

    // Back-to-back 64-byte frames, second valid raised during the first FCS.
    p = rand_bytes(64);
    p2 = rand_bytes(64);
    push_expected(p, -1, -1);
    push_expected(p2, -1, -1);
    send(p, -1, -1, stalls);
    send(p2, -1, -1, stalls);
    release_inputs();
    wait_idle();
    check("b2b_gap", 32'(gap_len[$]), 32'(IFG_BYTES + 1));
    check("b2b_len_first", 32'(run_len[run_len.size() - 2]), 32'd76);
    check("b2b_len_second", 32'(run_len[$]), 32'd76);

    // Reset at payload byte 30, then a clean 60-byte frame.
    p = rand_bytes(80);
    push_expected(p, -1, 30);
    send(p, -1, 30, stalls);
    @(negedge clock);
    check("rst_mid_tx_en", 32'(io_tx_en), 32'h0);
    check("rst_mid_busy", 32'(io_busy), 32'h0);
    check("rst_mid_flushed", 32'(sb_q.size()), 32'h0);
    reset = 1'b0;
    p = rand_bytes(60);
    push_expected(p, -1, -1);
    send(p, -1, -1, stalls);
    release_inputs();
    wait_idle();
    check("after_rst_len", 32'(run_len[$]), 32'd72);

    // Random lengths, contents, idle gaps and occasional underruns.
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 130);
      ur = (n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 1)) : -1;
      p = rand_bytes(n);
      repeat ($urandom_range(0, 4)) @(negedge clock);
      push_expected(p, ur, -1);
      send(p, ur, -1, stalls);
      release_inputs();
      wait_idle();
      check("rand_run_len", 32'(run_len[$]), 32'(expected_run(n, ur)));
    end

    repeat (5) @(negedge clock);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
